simon_seq_mem: RTL and testbench

Parametrised sequence store for the Simon Says game: the successor to the fixed 32-bit byte-loaded register memory. Symbols (colours) are appended one at a time at a tail pointer. They are read back through a playback cursor and checked against player input in hardware. It sits between the game FSM (append, playback, check control) and the LED/button front end (symbol display, player symbol).

---
 rtl/simon_seq_mem_pkg.sv | 33 +++
 rtl/simon_seq_mem_if.sv | 64 ++++++
 rtl/simon_seq_cursor.sv | 47 ++++
 rtl/simon_seq_mem.sv | 152 +++++++++++++++
 tb/tb_simon_seq_mem.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/simon_seq_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : simon_seq_pkg
//  Description : Shared colour codes, default sizing and cursor wrap helper
//                for the Simon Says sequence store.
//  Revision    : 1.0 - initial release
// ============================================================================
package simon_seq_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } colour_t;

    localparam int c_DEFAULT_SYM_W = 2;
    localparam int c_DEFAULT_DEPTH = 16;

    // Next playback position: one past cur, back to 0 after the last symbol.
    function automatic int unsigned cursor_wrap(input int unsigned cur, input int unsigned len);
        if (len == 0) begin
            return 0;
        end
        return ((cur + 1) >= len) ? 0 : cur + 1;
    endfunction

    function automatic int lane_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/simon_seq_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : simon_seq_mem_if
//  Description : Game-FSM side bus of the sequence store (append, playback,
//                check, status). SIMON_SEQ_BYTE_LOAD_EN adds the byte-load port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface simon_seq_mem_if
    import simon_seq_pkg::*;
#(
    parameter int SYM_W = c_DEFAULT_SYM_W,
    parameter int DEPTH = c_DEFAULT_DEPTH,
    parameter int LEN_W = $clog2(DEPTH + 1)
);
    localparam int LANE_W = lane_w(DEPTH * SYM_W / 8);

    logic                     app_valid;
    logic [SYM_W-1:0]         app_sym;
    logic                     rd_rewind;
    logic                     rd_next;
    logic                     chk_valid;
    logic [SYM_W-1:0]         chk_sym;
    logic [SYM_W-1:0]         rd_sym;
    logic                     rd_last;
    logic                     chk_done;
    logic                     chk_ok;
    logic                     seq_done;
    logic [LEN_W-1:0]         len;
    logic                     full;
    logic                     empty;
    logic                     ovf;
    logic [DEPTH*SYM_W-1:0]   seq_flat;
`ifdef SIMON_SEQ_BYTE_LOAD_EN
    logic                     bl_load;
    logic [7:0]               bl_byte;
    logic [LANE_W-1:0]        bl_lane;

    modport master (
        output app_valid, app_sym, rd_rewind, rd_next, chk_valid, chk_sym,
               bl_load, bl_byte, bl_lane,
        input  rd_sym, rd_last, chk_done, chk_ok, seq_done, len, full, empty,
               ovf, seq_flat
    );
    modport slave (
        input  app_valid, app_sym, rd_rewind, rd_next, chk_valid, chk_sym,
               bl_load, bl_byte, bl_lane,
        output rd_sym, rd_last, chk_done, chk_ok, seq_done, len, full, empty,
               ovf, seq_flat
    );
`else
    modport master (
        output app_valid, app_sym, rd_rewind, rd_next, chk_valid, chk_sym,
        input  rd_sym, rd_last, chk_done, chk_ok, seq_done, len, full, empty,
               ovf, seq_flat
    );
    modport slave (
        input  app_valid, app_sym, rd_rewind, rd_next, chk_valid, chk_sym,
        output rd_sym, rd_last, chk_done, chk_ok, seq_done, len, full, empty,
               ovf, seq_flat
    );
`endif

endinterface
`default_nettype wire

// File: rtl/simon_seq_cursor.sv
`default_nettype none
// ============================================================================
//  Module      : simon_seq_cursor
//  Description : Playback cursor with rewind/advance, wrapping against the
//                stored length, plus last-symbol decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module simon_seq_cursor
    import simon_seq_pkg::*;
#(
    parameter int LEN_W = 5
) (
    input  wire logic             clk,
    input  wire logic             rst_SEQ,
    input  wire logic             rewind,
    input  wire logic             advance,
    input  wire logic [LEN_W-1:0] len,
    output logic      [LEN_W-1:0] cursor,
    output logic                  rd_last
);

    logic [LEN_W-1:0] r_cur;
    logic [LEN_W-1:0] w_cur_nxt;

    // Rewind outranks advance; an advance on an empty store leaves the cursor alone.
    always_comb begin
        w_cur_nxt = r_cur;
        if (rewind) begin
            w_cur_nxt = '0;
        end else if (advance && (len != '0)) begin
            w_cur_nxt = LEN_W'(cursor_wrap(32'(r_cur), 32'(len)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst_SEQ) begin
            r_cur <= '0;
        end else begin
            r_cur <= w_cur_nxt;
        end
    end

    assign cursor  = r_cur;
    assign rd_last = (len != '0) && (r_cur == (len - LEN_W'(1)));

endmodule
`default_nettype wire

// File: rtl/simon_seq_mem.sv
`default_nettype none
// ============================================================================
//  Module      : simon_seq_mem
//  Description : Simon Says sequence store: tail append, playback cursor and
//                in-hardware check of player symbols. Optional byte-lane load
//                enabled by SIMON_SEQ_BYTE_LOAD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module simon_seq_mem
    import simon_seq_pkg::*;
#(
    parameter int SYM_W = c_DEFAULT_SYM_W,
    parameter int DEPTH = c_DEFAULT_DEPTH,
    parameter int LEN_W = $clog2(DEPTH + 1)
) (
    input  wire logic       clk,
    input  wire logic       rst_SEQ,
    simon_seq_mem_if.slave  bus
);

    localparam int c_FLAT_W = DEPTH * SYM_W;

    logic [c_FLAT_W-1:0] r_flat;
    logic [LEN_W-1:0]    r_len;
    logic                r_ovf;
    logic                r_chk_done;
    logic                r_chk_ok;
    logic                r_seq_done;

    logic [LEN_W-1:0]    w_cur;
    logic                w_rd_last;
    logic [SYM_W-1:0]    w_rd_sym;
    logic                w_full;
    logic                w_empty;
    logic                w_bl_load;
    logic                w_app_take;
    logic                w_app_drop;
    logic                w_chk_take;
    logic                w_next_take;
    logic                w_match;
    logic                w_advance;

    assign w_full  = (r_len == LEN_W'(DEPTH));
    assign w_empty = (r_len == '0);

`ifdef SIMON_SEQ_BYTE_LOAD_EN
    localparam int c_LANES  = c_FLAT_W / 8;
    localparam int c_LANE_W = lane_w(c_LANES);

    logic [LEN_W-1:0] w_bl_len;

    assign w_bl_load = bus.bl_load;

    // Length grows to cover the highest symbol that the written lane touches.
    always_comb begin
        w_bl_len = r_len;
        for (int j = 0; j < c_LANES; j++) begin
            if ((bus.bl_lane == c_LANE_W'(j)) && (LEN_W'(((j * 8 + 7) / SYM_W) + 1) > r_len)) begin
                w_bl_len = LEN_W'(((j * 8 + 7) / SYM_W) + 1);
            end
        end
    end
`else
    assign w_bl_load = 1'b0;
`endif

    // A byte load swallows a same-cycle append without flagging overflow.
    assign w_app_take  = bus.app_valid && !w_full && !w_bl_load;
    assign w_app_drop  = bus.app_valid &&  w_full && !w_bl_load;
    assign w_chk_take  = bus.chk_valid && !bus.rd_rewind;
    assign w_next_take = bus.rd_next && !bus.rd_rewind && !bus.chk_valid;
    assign w_match     = !w_empty && (bus.chk_sym == w_rd_sym);
    assign w_advance   = (w_chk_take && w_match) || w_next_take;

    simon_seq_cursor #(
        .LEN_W   (LEN_W)
    ) u_cursor (
        .clk     (clk),
        .rst_SEQ (rst_SEQ),
        .rewind  (bus.rd_rewind),
        .advance (w_advance),
        .len     (r_len),
        .cursor  (w_cur),
        .rd_last (w_rd_last)
    );

    always_comb begin
        w_rd_sym = '0;
        if (!w_empty) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_cur == LEN_W'(i)) begin
                    w_rd_sym = r_flat[i*SYM_W +: SYM_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_SEQ) begin
            r_flat <= '0;
            r_len  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_bl_load) begin
`ifdef SIMON_SEQ_BYTE_LOAD_EN
                for (int j = 0; j < c_LANES; j++) begin
                    if (bus.bl_lane == c_LANE_W'(j)) begin
                        r_flat[j*8 +: 8] <= bus.bl_byte;
                    end
                end
                r_len <= w_bl_len;
`endif
            end else if (w_app_take) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_len == LEN_W'(i)) begin
                        r_flat[i*SYM_W +: SYM_W] <= bus.app_sym;
                    end
                end
                r_len <= r_len + LEN_W'(1);
            end
            if (w_app_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Check result uses the cursor, store and length as they stood before this edge.
    always_ff @(posedge clk) begin
        if (rst_SEQ) begin
            r_chk_done <= 1'b0;
            r_chk_ok   <= 1'b0;
            r_seq_done <= 1'b0;
        end else begin
            r_chk_done <= w_chk_take;
            r_chk_ok   <= w_chk_take && w_match;
            r_seq_done <= w_chk_take && w_match && w_rd_last;
        end
    end

    assign bus.rd_sym   = w_rd_sym;
    assign bus.rd_last  = w_rd_last;
    assign bus.chk_done = r_chk_done;
    assign bus.chk_ok   = r_chk_ok;
    assign bus.seq_done = r_seq_done;
    assign bus.len      = r_len;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.ovf      = r_ovf;
    assign bus.seq_flat = r_flat;

endmodule
`default_nettype wire

// File: tb/tb_simon_seq_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_simon_seq_mem
//  Description : Directed and random stimulus for simon_seq_mem against a
//                symbol-list reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_simon_seq_mem;
    import simon_seq_pkg::*;

    localparam int SYM_W  = 2;
    localparam int DEPTH  = 16;
    localparam int LEN_W  = $clog2(DEPTH + 1);
    localparam int LANE_W = lane_w(DEPTH * SYM_W / 8);

    logic clk = 1'b0;
    logic rst_SEQ;

    always #5 clk = ~clk;

    simon_seq_mem_if #(.SYM_W(SYM_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) bus ();

    simon_seq_mem #(.SYM_W(SYM_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk     (clk),
        .rst_SEQ (rst_SEQ),
        .bus     (bus)
    );

    int m_store [DEPTH];
    int m_len;
    int m_cur;
    bit m_ovf;
    bit e_done, e_ok, e_sd;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [DEPTH*SYM_W-1:0] f;
        int rs;
        f = '0;
        for (int i = 0; i < DEPTH; i++) f[i*SYM_W +: SYM_W] = SYM_W'(m_store[i]);
        rs = (m_len > 0) ? m_store[m_cur] : 0;
        chk("chk_done", bus.chk_done, e_done);
        chk("chk_ok",   bus.chk_ok,   e_ok);
        chk("seq_done", bus.seq_done, e_sd);
        chk("len",      bus.len,      m_len);
        chk("full",     bus.full,     m_len == DEPTH);
        chk("empty",    bus.empty,    m_len == 0);
        chk("ovf",      bus.ovf,      m_ovf);
        chk("rd_sym",   bus.rd_sym,   rs);
        chk("rd_last",  bus.rd_last,  (m_len != 0) && (m_cur == m_len - 1));
        chk("seq_flat", bus.seq_flat, f);
    endtask

    task automatic step(input bit rst, input bit appv, input int apps, input bit rew,
                        input bit nxt, input bit chkv, input int chks,
                        input bit bl = 0, input int lane = 0, input int byt = 0);
        int idx, bit_pos, top;
        rst_SEQ       = rst;
        bus.app_valid = appv;
        bus.app_sym   = SYM_W'(apps);
        bus.rd_rewind = rew;
        bus.rd_next   = nxt;
        bus.chk_valid = chkv;
        bus.chk_sym   = SYM_W'(chks);
`ifdef SIMON_SEQ_BYTE_LOAD_EN
        bus.bl_load   = bl;
        bus.bl_lane   = LANE_W'(lane);
        bus.bl_byte   = 8'(byt);
`endif
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_store[i] = 0;
            m_len = 0; m_cur = 0; m_ovf = 0;
            e_done = 0; e_ok = 0; e_sd = 0;
        end else begin
            e_done = 0; e_ok = 0; e_sd = 0;
            if (rew) begin
                m_cur = 0;
            end else if (chkv) begin
                e_done = 1;
                if (m_len > 0 && m_store[m_cur] == chks) begin
                    e_ok = 1;
                    if (m_cur == m_len - 1) begin
                        e_sd = 1;
                        m_cur = 0;
                    end else begin
                        m_cur++;
                    end
                end
            end else if (nxt && m_len > 0) begin
                m_cur = (m_cur + 1) % m_len;
            end
            if (bl) begin
                for (int b = 0; b < 8; b++) begin
                    idx     = (lane * 8 + b) / SYM_W;
                    bit_pos = (lane * 8 + b) % SYM_W;
                    m_store[idx] = (m_store[idx] & ~(1 << bit_pos)) | (((byt >> b) & 1) << bit_pos);
                end
                top = (lane * 8 + 7) / SYM_W + 1;
                if (top > m_len) m_len = top;
            end else if (appv) begin
                if (m_len < DEPTH) begin
                    m_store[m_len] = apps;
                    m_len++;
                end else begin
                    m_ovf = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit r_rst, r_app, r_rew, r_nxt, r_chk, r_bl;
        int r_sym, r_chs;
        rst_SEQ = 1'b1;
        bus.app_valid = 0; bus.app_sym = '0; bus.rd_rewind = 0; bus.rd_next = 0;
        bus.chk_valid = 0; bus.chk_sym = '0;
`ifdef SIMON_SEQ_BYTE_LOAD_EN
        bus.bl_load = 0; bus.bl_lane = '0; bus.bl_byte = '0;
`endif
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // Append 3,1,2
        step(0, 1, YELLOW, 0, 0, 0, 0);
        step(0, 1, GREEN,  0, 0, 0, 0);
        step(0, 1, BLUE,   0, 0, 0, 0);
        chk("flat_312", bus.seq_flat[5:0], 6'b10_01_11);
        chk("len_3",    bus.len, 3);
        chk("rd_sym_3", bus.rd_sym, 3);

        // Checks 3, 1, 0 (mismatch), 2 (last)
        step(0, 0, 0, 0, 0, 1, 3);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("ok_after_mismatch", bus.chk_ok, 0);
        step(0, 0, 0, 0, 0, 1, 2);
        chk("seq_done_last", bus.seq_done, 1);
        chk("cursor_back_0", bus.rd_sym, 3);
        idle();

        // Playback with wrap, then rewind beats next
        repeat (4) step(0, 0, 0, 0, 1, 0, 0);
        chk("wrap_rd_sym", bus.rd_sym, 1);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1, 1);
        chk("chk_with_rewind", bus.chk_done, 0);
        // Check and append together, then reset over a pending check
        step(0, 1, RED, 0, 0, 1, 3);
        step(1, 0, 0, 0, 0, 1, 3);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("empty_chk_ok", bus.chk_ok, 0);

        // Overflow: DEPTH+1 appends, ovf sticky until reset
        for (int i = 0; i <= DEPTH; i++) step(0, 1, i % 4, 0, 0, 0, 0);
        repeat (3) idle();
        chk("ovf_sticky", bus.ovf, 1);
        step(1, 0, 0, 0, 0, 0, 0);

`ifdef SIMON_SEQ_BYTE_LOAD_EN
        step(0, 1, 3, 0, 0, 0, 0, 1, 1, 8'hE4);
        chk("bl_len_8",  bus.len, 8);
        chk("bl_sym4_7", bus.seq_flat[15:8], 8'hE4);
        chk("bl_no_ovf", bus.ovf, 0);
        step(1, 0, 0, 0, 0, 0, 0);
`endif

        for (int n = 0; n < 800; n++) begin
            r_rst = ($urandom_range(0, 99) < 2);
            r_app = ($urandom_range(0, 9) < 3);
            r_sym = $urandom_range(0, 3);
            r_rew = ($urandom_range(0, 19) == 0);
            r_nxt = ($urandom_range(0, 4) == 0);
            r_chk = ($urandom_range(0, 9) < 4);
            r_chs = (m_len > 0 && $urandom_range(0, 9) < 7) ? m_store[m_cur] : $urandom_range(0, 3);
            r_bl  = 0;
`ifdef SIMON_SEQ_BYTE_LOAD_EN
            r_bl  = ($urandom_range(0, 19) == 0);
`endif
            step(r_rst, r_app, r_sym, r_rew, r_nxt, r_chk, r_chs,
                 r_bl, $urandom_range(0, (DEPTH * SYM_W / 8) - 1), $urandom_range(0, 255));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
